// File: rtl/dino_pkg.sv
// Shared definitions for the dino jump controller and the VGA sprite renderer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dino_pkg;

  typedef enum logic [2:0] {
    ST_GROUND = 3'd0,
    ST_RISE   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_FALL   = 3'd3,
    ST_COOL   = 3'd4,
    ST_DEAD   = 3'd5
  } dino_state_t;

  localparam logic [7:0] KEY_JUMP    = 8'h29;  // space
  localparam logic [7:0] KEY_RESTART = 8'h5A;  // enter

  // Renderer and controller must agree on where the ground line is.
  localparam int DEF_GROUND_Y = 291;
  localparam int DEF_SPRITE_H = 30;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dino_jump_ctrl_tick_gen.sv
// Motion tick divider: one-cycle pulse every DIV clk cycles.
// Latency: first pulse on the DIV-th clk edge after reset release.
// Backpressure: none; free-running.
module tick_gen #(
  parameter int DIV = 262144
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running count 0..DIV-1, wrapping on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/dino_jump_ctrl.sv
// Dino jump controller: key edges drive a jump FSM producing sprite rows and game status.
// Latency: key edge or collision acts on the next clk; motion advances one pixel per tick.
// Backpressure: none; one jump request may be buffered while a jump is in progress.
module dino_jump_ctrl
  import dino_pkg::*;
#(
  parameter int TICK_DIV    = 262144,
  parameter int JUMP_HEIGHT = 80,
  parameter int APEX_HOLD   = 4,
  parameter int COOL_TICKS  = 8,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int LEG_TICKS   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  keycode,
  input  logic        collision,
  output logic [10:0] dino_top,
  output logic [10:0] dino_bottom,
  output logic        airborne,
  output logic        game_over,
  output logic        leg_phase,
  output logic [15:0] jump_count,
  output logic [2:0]  state
);

  localparam logic [6:0]  H_TOP     = 7'(JUMP_HEIGHT);
  localparam logic [7:0]  HOLD_LAST = 8'(APEX_HOLD);
  localparam logic [7:0]  COOL_LAST = 8'(COOL_TICKS);
  localparam logic [7:0]  LEG_LAST  = 8'(LEG_TICKS);
  localparam logic [10:0] Y_GND     = 11'(GROUND_Y);
  localparam logic [10:0] Y_SPAN    = 11'(SPRITE_H);

  logic        tick;
  logic [7:0]  key_q;
  logic        jump_req;
  logic        restart_req;

  dino_state_t state_q, state_d;
  logic [6:0]  h_q, h_d;
  logic [7:0]  cnt_q, cnt_d;          // ticks spent in HOLD or COOL
  logic [7:0]  leg_cnt_q, leg_cnt_d;  // ticks since last leg toggle
  logic        leg_q, leg_d;
  logic        pend_q, pend_d;
  logic [15:0] jc_q, jc_d;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // A held key must not retrigger: only the first sample of a code counts.
  assign jump_req    = (keycode == KEY_JUMP)    && (key_q != KEY_JUMP);
  assign restart_req = (keycode == KEY_RESTART) && (key_q != KEY_RESTART);

  // Next-state, motion, buffering and animation; collision overrides everything but DEAD.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    cnt_d     = cnt_q;
    leg_cnt_d = leg_cnt_q;
    leg_d     = leg_q;
    pend_d    = pend_q;
    jc_d      = jc_q;

    if (collision && (state_q != ST_DEAD)) begin
      state_d = ST_DEAD;
      pend_d  = 1'b0;
    end else begin
      if (tick && ((state_q == ST_GROUND) || (state_q == ST_COOL))) begin
        if (leg_cnt_q + 8'd1 >= LEG_LAST) begin
          leg_cnt_d = '0;
          leg_d     = ~leg_q;
        end else begin
          leg_cnt_d = leg_cnt_q + 8'd1;
        end
      end

      case (state_q)
        ST_GROUND: begin
          if (jump_req) state_d = ST_RISE;
        end
        ST_RISE: begin
          if (jump_req) pend_d = 1'b1;
          if (tick) begin
            if (h_q < H_TOP) h_d = h_q + 7'd1;
            if (h_q + 7'd1 >= H_TOP) begin
              state_d = ST_HOLD;
              cnt_d   = '0;
            end
          end
        end
        ST_HOLD: begin
          if (jump_req) pend_d = 1'b1;
          if (tick) begin
            if (cnt_q + 8'd1 >= HOLD_LAST) begin
              state_d = ST_FALL;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_FALL: begin
          if (jump_req) pend_d = 1'b1;
          if (tick) begin
            if (h_q != 7'd0) h_d = h_q - 7'd1;
            if (h_q <= 7'd1) begin
              state_d = ST_COOL;
              cnt_d   = '0;
              jc_d    = sat_inc16(jc_q);
            end
          end
        end
        ST_COOL: begin
          if (jump_req) pend_d = 1'b1;
          if (tick) begin
            if (cnt_q + 8'd1 >= COOL_LAST) begin
              cnt_d = '0;
              // A press landing on the very last cooling tick still counts as buffered.
              if (pend_q || jump_req) begin
                state_d = ST_RISE;
                pend_d  = 1'b0;
              end else begin
                state_d = ST_GROUND;
              end
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_DEAD: begin
          if (restart_req) begin
            state_d   = ST_GROUND;
            h_d       = '0;
            cnt_d     = '0;
            leg_cnt_d = '0;
            leg_d     = 1'b0;
            pend_d    = 1'b0;
            jc_d      = '0;
          end
        end
        default: state_d = ST_GROUND;
      endcase
    end
  end

  // State register plus registered sprite rows derived from the next height.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_GROUND;
      key_q       <= '0;
      h_q         <= '0;
      cnt_q       <= '0;
      leg_cnt_q   <= '0;
      leg_q       <= 1'b0;
      pend_q      <= 1'b0;
      jc_q        <= '0;
      dino_top    <= Y_GND;
      dino_bottom <= Y_GND + Y_SPAN;
    end else begin
      state_q     <= state_d;
      key_q       <= keycode;
      h_q         <= h_d;
      cnt_q       <= cnt_d;
      leg_cnt_q   <= leg_cnt_d;
      leg_q       <= leg_d;
      pend_q      <= pend_d;
      jc_q        <= jc_d;
      dino_top    <= Y_GND - {4'd0, h_d};
      dino_bottom <= Y_GND - {4'd0, h_d} + Y_SPAN;
    end
  end

  assign airborne   = (state_q == ST_RISE) || (state_q == ST_HOLD) || (state_q == ST_FALL);
  assign game_over  = (state_q == ST_DEAD);
  assign leg_phase  = leg_q;
  assign jump_count = jc_q;
  assign state      = state_q;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Scoreboard bench for dino_jump_ctrl with a jump-timeline reference model.
// Latency: expected values are queued per clk edge and checked just after it.
// Backpressure: n/a.
module tb_dino_jump_ctrl;

  localparam int TD = 4;
  localparam int JH = 8;
  localparam int AH = 2;
  localparam int CT = 3;
  localparam int LT = 2;
  localparam int GY = 291;
  localparam int SH = 30;

  // Jump timeline measured in ticks since take-off.
  localparam int RISE_END = JH;
  localparam int HOLD_END = JH + AH;
  localparam int FALL_END = 2 * JH + AH;
  localparam int COOL_END = 2 * JH + AH + CT;

  typedef struct packed {
    logic [2:0]  st;
    logic [10:0] top;
    logic [10:0] bot;
    logic        air;
    logic        go;
    logic        leg;
    logic [15:0] jc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  keycode;
  logic        collision;
  logic [10:0] dino_top, dino_bottom;
  logic        airborne, game_over, leg_phase;
  logic [15:0] jump_count;
  logic [2:0]  state;

  int vectors = 0;
  int miscompares = 0;
  obs_t exp_q[$];

  dino_jump_ctrl #(
    .TICK_DIV(TD), .JUMP_HEIGHT(JH), .APEX_HOLD(AH), .COOL_TICKS(CT),
    .GROUND_Y(GY), .SPRITE_H(SH), .LEG_TICKS(LT)
  ) dut (
    .clk(clk), .rst(rst), .keycode(keycode), .collision(collision),
    .dino_top(dino_top), .dino_bottom(dino_bottom), .airborne(airborne),
    .game_over(game_over), .leg_phase(leg_phase), .jump_count(jump_count),
    .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = on the ground idle, 1 = somewhere in a jump, 2 = dead.
  int         m_mode, m_t, m_hdead, m_leg_ticks, m_jumps, m_edges;
  bit         m_pend;
  logic [7:0] m_prev;

  function automatic int m_h();
    if (m_mode == 2) return m_hdead;
    if (m_mode == 0) return 0;
    if (m_t < RISE_END) return m_t;
    if (m_t < HOLD_END) return JH;
    if (m_t < FALL_END) return FALL_END - m_t;
    return 0;
  endfunction

  function automatic int m_code();
    if (m_mode == 2) return 5;
    if (m_mode == 0) return 0;
    if (m_t < RISE_END) return 1;
    if (m_t < HOLD_END) return 2;
    if (m_t < FALL_END) return 3;
    return 4;
  endfunction

  function automatic obs_t m_expect();
    obs_t o;
    int c;
    c     = m_code();
    o.st  = 3'(c);
    o.top = 11'(GY - m_h());
    o.bot = 11'(GY - m_h() + SH);
    o.air = (c >= 1) && (c <= 3);
    o.go  = (c == 5);
    o.leg = ((m_leg_ticks / LT) % 2) == 1;
    o.jc  = 16'(m_jumps);
    return o;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_t = 0; m_hdead = 0; m_leg_ticks = 0;
    m_jumps = 0; m_edges = 0; m_pend = 0; m_prev = 8'h00;
  endtask

  task automatic m_step(input logic [7:0] k, input bit c, input bit r);
    bit tk, jr, rr;
    if (r) begin
      m_reset();
      return;
    end
    m_edges++;
    tk = (m_edges % TD) == 0;
    jr = (k == 8'h29) && (m_prev != 8'h29);
    rr = (k == 8'h5A) && (m_prev != 8'h5A);
    m_prev = k;
    if (m_mode == 2) begin
      if (rr) begin
        m_mode = 0; m_t = 0; m_jumps = 0; m_pend = 0; m_leg_ticks = 0;
      end
    end else if (c) begin
      m_hdead = m_h();
      m_mode  = 2;
      m_pend  = 0;
    end else if (m_mode == 0) begin
      if (tk) m_leg_ticks++;
      if (jr) begin
        m_mode = 1;
        m_t    = 0;
      end
    end else begin
      if (tk) begin
        if (m_t >= FALL_END) m_leg_ticks++;
        m_t++;
        if (m_t == FALL_END && m_jumps < 65535) m_jumps++;
      end
      if (m_t == COOL_END) begin
        if (m_pend || jr) begin
          m_t    = 0;
          m_pend = 0;
        end else begin
          m_mode = 0;
        end
      end else if (jr) begin
        m_pend = 1;
      end
    end
  endtask

  // Drive one clk of stimulus and queue what the DUT must show after that edge.
  task automatic drive(input logic [7:0] k, input bit c, input bit r);
    @(negedge clk);
    keycode   = k;
    collision = c;
    rst       = r;
    m_step(k, c, r);
    exp_q.push_back(m_expect());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b1);
    drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic wait_code(input int code, input int maxc, input string tag);
    int n = 0;
    while (m_code() != code && n < maxc) begin
      drive(8'h00, 1'b0, 1'b0);
      n++;
    end
    if (m_code() != code) begin
      miscompares++;
      $display("FAIL %s: timed out, state %0d, required %0d", tag, m_code(), code);
    end
  endtask

  // Monitor: compare every queued expectation just after its clk edge.
  initial begin
    obs_t act, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e       = exp_q.pop_front();
        act.st  = state;
        act.top = dino_top;
        act.bot = dino_bottom;
        act.air = airborne;
        act.go  = game_over;
        act.leg = leg_phase;
        act.jc  = jump_count;
        vectors++;
        if (act !== e)
          $display("FAIL outputs @%0t: got st=%0d top=%0d bot=%0d air=%b go=%b leg=%b jc=%0d, required st=%0d top=%0d bot=%0d air=%b go=%b leg=%b jc=%0d",
                   $time, act.st, act.top, act.bot, act.air, act.go, act.leg, act.jc,
                   e.st, e.top, e.bot, e.air, e.go, e.leg, e.jc);
        if (act !== e) miscompares++;
      end
    end
  end

  initial begin
    logic [7:0] k;
    bit         c, r;
    int         p;
    keycode = 8'h00; collision = 1'b0; rst = 1'b1;
    m_reset();

    // Full jump from the ground and back.
    do_reset();
    idle(2);
    drive(8'h29, 1'b0, 1'b0);
    idle(100);

    // Key held down produces a single jump.
    do_reset();
    idle(1);
    for (int i = 0; i < 100; i++) drive(8'h29, 1'b0, 1'b0);
    idle(40);

    // Two presses during the fall buffer exactly one follow-up jump.
    do_reset();
    drive(8'h29, 1'b0, 1'b0);
    wait_code(3, 200, "reach_fall");
    drive(8'h29, 1'b0, 1'b0);
    idle(2);
    drive(8'h29, 1'b0, 1'b0);
    idle(1);
    wait_code(0, 400, "back_to_ground");
    idle(20);

    // Collision mid-rise freezes, jump ignored, restart clears.
    do_reset();
    drive(8'h29, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!(m_code() == 1 && m_h() == 5) && n < 100) begin
        drive(8'h00, 1'b0, 1'b0);
        n++;
      end
      if (!(m_code() == 1 && m_h() == 5)) begin
        miscompares++;
        $display("FAIL reach_h5: timed out, h %0d, required 5", m_h());
      end
    end
    drive(8'h00, 1'b1, 1'b0);
    idle(10);
    drive(8'h29, 1'b0, 1'b0);
    idle(10);
    drive(8'h5A, 1'b0, 1'b0);
    idle(10);

    // Collision and jump edge in the same clk.
    do_reset();
    idle(1);
    drive(8'h29, 1'b1, 1'b0);
    idle(10);
    drive(8'h5A, 1'b0, 1'b0);
    idle(3);

    // Reset while holding at the apex.
    do_reset();
    drive(8'h29, 1'b0, 1'b0);
    wait_code(2, 200, "reach_hold");
    drive(8'h00, 1'b0, 1'b1);
    idle(10);

    // Randomized play.
    do_reset();
    k = 8'h00;
    for (int i = 0; i < 4000; i++) begin
      p = $urandom_range(0, 99);
      if (p < 8)       k = 8'h29;
      else if (p < 11) k = 8'h5A;
      else if (p < 60) k = k;
      else if (p < 95) k = 8'h00;
      else             k = 8'($urandom_range(0, 255));
      c = ($urandom_range(0, 59) == 0);
      r = ($urandom_range(0, 499) == 0);
      drive(k, c, r);
    end
    idle(3);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dino_jump_ctrl.md
DINO_JUMP_CTRL -- requirements
Module: dino_jump_ctrl

Interface
REQ-001 The module SHALL have the following parameters (name, default, meaning):
- TICK_DIV, 262144: clk cycles per motion tick.
- JUMP_HEIGHT, 80: apex rise in pixels.
- APEX_HOLD, 4: ticks held at the apex.
- COOL_TICKS, 8: ticks grounded after landing before a new jump may start.
- GROUND_Y, 291: dino_top value when grounded.
- SPRITE_H, 30: dino_bottom minus dino_top.
- LEG_TICKS, 16: ticks per leg_phase toggle.
REQ-002 The module SHALL have one clock and a synchronous active-high reset, with these ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst, in, 1: synchronous active-high reset.
- keycode, in, 8: held PS/2 scan code; 0 means no key.
- collision, in, 1: level, obstacle overlap.
- dino_top, out, 11: sprite upper row.
- dino_bottom, out, 11: sprite lower row.
- airborne, out, 1: high in RISE, HOLD and FALL.
- game_over, out, 1: high in DEAD.
- leg_phase, out, 1: selects the leg frame.
- jump_count, out, 16: completed jumps.
- state, out, 3: encoded FSM state.

Function
REQ-003 The block SHALL derive a one-clk tick pulse every TICK_DIV clk cycles from a free-running counter; no derived clocks.
REQ-004 The block SHALL register keycode each clk; jump_req SHALL pulse for one clk when keycode==8'h29 and the previous sample !=8'h29.
REQ-005 The block SHALL generate restart_req the same way on keycode 8'h5A.
REQ-006 The FSM SHALL have the states GROUND=0, RISE=1, HOLD=2, FALL=3, COOL=4, DEAD=5.
REQ-007 Height h (7 bits minimum) SHALL satisfy dino_top = GROUND_Y - h and dino_bottom = dino_top + SPRITE_H, with both outputs registered and 11 bits wide.
REQ-008 GROUND plus jump_req SHALL enter RISE on the next clk; h SHALL be unchanged until the next tick.
REQ-009 RISE SHALL increment h by 1 per tick; on the tick where h becomes JUMP_HEIGHT, the FSM SHALL enter HOLD.
REQ-010 HOLD SHALL count APEX_HOLD ticks and then enter FALL.
REQ-011 FALL SHALL decrement h by 1 per tick; on the tick where h becomes 0, the FSM SHALL enter COOL and jump_count SHALL increment, saturating at 16'hFFFF.
REQ-012 COOL SHALL count COOL_TICKS ticks and then enter RISE if pending is set (clearing pending), otherwise GROUND.
REQ-013 A jump_req arriving in RISE, HOLD, FALL or COOL SHALL set a one-deep pending flag; further requests while pending is set SHALL be dropped.
REQ-014 h SHALL never exceed JUMP_HEIGHT and never underflow below 0.
REQ-015 collision high in any state other than DEAD SHALL enter DEAD on the next clk, freezing h, leg_phase and jump_count, and clearing pending.
REQ-016 When collision and jump_req occur in the same clk, collision SHALL win.
REQ-017 In DEAD, jump_req SHALL be ignored; restart_req SHALL enter GROUND with h=0, jump_count=0, pending=0 and leg_phase=0.
REQ-018 leg_phase SHALL toggle every LEG_TICKS ticks in GROUND and COOL, and hold its value in all other states.
REQ-019 A state transition and a tick in the same clk SHALL apply the tick action of the current (pre-transition) state only.
REQ-020 Outputs SHALL change only on clk rising edges.

Reset
REQ-021 While rst is high, the block SHALL hold:
- state=GROUND, h=0, dino_top=GROUND_Y, dino_bottom=GROUND_Y+SPRITE_H;
- airborne=0, game_over=0, leg_phase=0, jump_count=0, pending=0;
- tick counter=0, keycode history=0.
REQ-022 Reset asserted mid-jump or in DEAD SHALL take effect at the next clk edge with no residual motion.

Structure
REQ-023 Package dino_pkg SHALL hold the state encoding, KEY_JUMP=8'h29, KEY_RESTART=8'h5A, and the GROUND_Y/SPRITE_H defaults shared with the VGA sprite renderer.
REQ-024 The tick divider SHALL be a separate sub-module, tick_gen (parameter DIV, ports clk, rst, tick); all other logic SHALL reside in dino_jump_ctrl.

Verification (TICK_DIV=4, JUMP_HEIGHT=8, APEX_HOLD=2, COOL_TICKS=3, LEG_TICKS=2)
REQ-025 The bench SHALL cover these directed scenarios:
- Full jump: keycode 0 then 8'h29 -> RISE next clk; dino_top falls 291 to 283 over 8 ticks; 2 ticks at 283; rises to 291 over 8 ticks; COOL for 3 ticks; GROUND; jump_count=1.
- Held key: keycode held at 8'h29 for 100 clks -> exactly one jump; jump_count=1.
- Buffering: second and third 8'h29 presses during FALL -> exactly one extra jump starts as COOL ends; jump_count=2.
- Collision: collision pulse at h=5 during RISE -> DEAD next clk; dino_top=286 frozen; 8'h29 ignored; 8'h5A -> GROUND, dino_top=291, jump_count=0.
- Simultaneous: collision and new 8'h29 edge in the same clk in GROUND -> DEAD, never RISE.
- Reset: rst asserted during HOLD -> next clk state=GROUND, dino_top=291, dino_bottom=321, all flags 0.
